seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
//  Receive side of the multiplexed 7-segment scan bus (seg[6:0] + de[2:0]) driven by the timer.
//  Samples the bus, decodes each segment pattern back to BCD, and assembles six digits (H1 H0 M1 M0 S1 S0).
//  Publishes a complete frame with a one-cycle strobe.
//  Used for on-board self-check of the display path and as a bench monitor.
// PARAMETERS
//  NDIG    6  digits per frame; valid de values are 0..NDIG-1
//  SETTLE  4  consecutive identical samples required before a digit is captured (>=2)
// PORTS
//  mclk         in   1        system clock; the only clock
//  rst          in   1        reset, asynchronous, active-high
//  seg          in   7        segment bus, bit6=a .. bit0=g, 1=lit; asynchronous to mclk
//  de           in   3        digit select; asynchronous to mclk
//  time_bcd     out  4*NDIG   last published frame, digit 0 (H1) in the MS nibble
//  frame_valid  out  1        1-cycle pulse: time_bcd updated this cycle
//  frame_err    out  1        valid with frame_valid: >=1 digit had an undecodable pattern
//  seq_err      out  1        1-cycle pulse: scan order violation; partial frame discarded
// BEHAVIOUR
//  - Reset: time_bcd=0, frame_valid=0, frame_err=0, seq_err=0, expected index=0.
//    Synchronisers, stability counter and shadow digits are cleared.
//    rst asserted mid-frame discards the partial frame. No publish until a full 0..NDIG-1 scan completes.
//  - Input path: seg and de pass through 2-flop synchronisers.
//    Stability counter resets to 1 whenever the synced {de,seg} differs from the previous cycle, else increments.
//    The counter saturates at SETTLE.
//  - Capture: on the edge where the counter reaches SETTLE, once per dwell.
//    There is no re-capture until {de,seg} changes. A dwell shorter than SETTLE is never captured.
//  - Decode: 0=1111110 1=0110000 2=1101101 3=1111001 4=0110011 5=1011011 6=1011111 7=1110000 8=1111111 9=1111011.
//    Any other pattern decodes to 4'hF and sets the frame's bad flag.
//  - Sequencer states: HUNT (expect 0) and COLLECT (expect k, 1<=k<=NDIG-1).
//  - Capture with index == expected: store nibble in shadow; expected++.
//  - Capture of index NDIG-1 while in COLLECT: publish. On the same edge, time_bcd <= shadow plus the new nibble.
//    frame_valid=1 and frame_err=bad, then expected=0 and bad is cleared.
//  - Capture with index != expected, or de >= NDIG: seq_err=1 for one cycle, shadow and bad cleared.
//    If the offending index is 0, it is stored and expected=1; otherwise the sequencer goes to HUNT.
//  - In HUNT, captures with a nonzero index are ignored silently, with no seq_err.
//  - frame_err holds its value until the next publish.
//  - Latency: bus change to capture = 2 (sync) + SETTLE cycles.
//  - NDIG=1 degenerates to a publish on every capture of index 0.
// STRUCTURE
//  - Package seg7_pkg: the ten segment patterns as localparams and the error glyph 7'b0011111.
//    The timer's encoder uses the same package.
//  - Sub-module seg7_to_bcd: combinational 7-bit pattern -> {bad, bcd[3:0]}.
//  - Synchronisers, stability counter ($clog2(SETTLE+1) bits) and sequencer stay in this module.
// TESTING
//  - Scan 12:34:56, dwell 10 cycles/digit, SETTLE=4 -> one frame_valid after digit 5;
//    time_bcd=24'h123456, frame_err=0, seq_err never set.
//  - Digit 2 seg toggles 8<->3 for 2 cycles, then holds 3 for 10 cycles -> captured 3, time_bcd=24'h123456.
//  - Order 0,1,3 -> seq_err pulse at the digit-3 capture, no frame_valid.
//    A following clean scan of 00:00:07 -> time_bcd=24'h000007.
//  - Digit 4 pattern 0011111 in scan 12:34:56 -> frame_valid with time_bcd=24'h1234F6, frame_err=1.
//    The next clean frame clears frame_err.
//  - rst pulsed after digit 3 of a scan -> all outputs 0.
//    The remainder of that scan plus de=6 yields no frame_valid; the next full scan publishes.
//  - Digit 1 dwell of 3 cycles (< SETTLE) -> digit 1 not captured.
//    seq_err at the digit-2 capture; no publish for that scan.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - seven-segment glyphs shared by the scan encoder and decoder
package seg7_pkg;

  // Bit 6 is segment a, bit 0 is segment g; 1 means lit.
  localparam logic [6:0] SEG_0   = 7'b1111110;
  localparam logic [6:0] SEG_1   = 7'b0110000;
  localparam logic [6:0] SEG_2   = 7'b1101101;
  localparam logic [6:0] SEG_3   = 7'b1111001;
  localparam logic [6:0] SEG_4   = 7'b0110011;
  localparam logic [6:0] SEG_5   = 7'b1011011;
  localparam logic [6:0] SEG_6   = 7'b1011111;
  localparam logic [6:0] SEG_7   = 7'b1110000;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1111011;
  localparam logic [6:0] SEG_ERR = 7'b0011111;

  typedef enum logic {
    SEQ_HUNT,
    SEQ_COLLECT
  } seq_state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// rtl/seg7_to_bcd.sv - combinational segment pattern to BCD digit decoder
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] bcd_o,
  output logic       bad_o
);

  always_comb begin
    bcd_o = 4'hF;
    bad_o = 1'b0;
    case (pattern_i)
      SEG_0:   bcd_o = 4'd0;
      SEG_1:   bcd_o = 4'd1;
      SEG_2:   bcd_o = 4'd2;
      SEG_3:   bcd_o = 4'd3;
      SEG_4:   bcd_o = 4'd4;
      SEG_5:   bcd_o = 4'd5;
      SEG_6:   bcd_o = 4'd6;
      SEG_7:   bcd_o = 4'd7;
      SEG_8:   bcd_o = 4'd8;
      SEG_9:   bcd_o = 4'd9;
      default: bad_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - samples the multiplexed 7-segment scan bus and rebuilds time frames
module seg_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NDIG   = 6,
  parameter int SETTLE = 4
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic [6:0]        seg,
  input  logic [2:0]        de,
  output logic [4*NDIG-1:0] time_bcd,
  output logic              frame_valid,
  output logic              frame_err,
  output logic              seq_err
);

  localparam int            CW       = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SETTLE);
  localparam logic [CW-1:0] CNT_ARM  = CW'(SETTLE - 1);
  localparam logic [2:0]    LAST_IDX = 3'(NDIG - 1);

  logic [6:0]        seg_s1_q, seg_s2_q;
  logic [2:0]        de_s1_q, de_s2_q;
  logic [9:0]        prev_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  seq_state_e        state_q, state_d;
  logic [2:0]        exp_q, exp_d;
  logic [4*NDIG-1:0] shadow_q, shadow_d;
  logic [4*NDIG-1:0] time_q, time_d;
  logic              bad_q, bad_d;
  logic              fv_q, fv_d;
  logic              ferr_q, ferr_d;
  logic              serr_q, serr_d;

  logic              same;
  logic              capture;
  logic [3:0]        nib;
  logic              nib_bad;
  logic [4*NDIG-1:0] merged;

  seg7_to_bcd u_dec (
    .pattern_i (seg_s2_q),
    .bcd_o     (nib),
    .bad_o     (nib_bad)
  );

  assign same    = ({de_s2_q, seg_s2_q} == prev_q);
  // Fires exactly once per dwell: the cycle the count steps onto SETTLE.
  assign capture = same && (cnt_q == CNT_ARM);

  always_comb begin
    cnt_d = cnt_q;
    if (!same) begin
      cnt_d = CW'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Shadow with the freshly decoded nibble dropped into its slot; digit 0 is the MS nibble.
  always_comb begin
    merged = shadow_q;
    for (int i = 0; i < NDIG; i++) begin
      if (de_s2_q == 3'(i)) begin
        merged[4*(NDIG-1-i) +: 4] = nib;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    shadow_d = shadow_q;
    bad_d    = bad_q;
    time_d   = time_q;
    fv_d     = 1'b0;
    ferr_d   = ferr_q;
    serr_d   = 1'b0;
    if (capture) begin
      if (state_q == SEQ_HUNT) begin
        if (de_s2_q == 3'd0) begin
          if (NDIG == 1) begin
            time_d = merged;
            fv_d   = 1'b1;
            ferr_d = nib_bad;
          end else begin
            shadow_d = merged;
            bad_d    = nib_bad;
            exp_d    = 3'd1;
            state_d  = SEQ_COLLECT;
          end
        end
      end else if (de_s2_q == exp_q) begin
        if (de_s2_q == LAST_IDX) begin
          time_d  = merged;
          fv_d    = 1'b1;
          ferr_d  = bad_q | nib_bad;
          bad_d   = 1'b0;
          exp_d   = 3'd0;
          state_d = SEQ_HUNT;
        end else begin
          shadow_d = merged;
          bad_d    = bad_q | nib_bad;
          exp_d    = exp_q + 3'd1;
        end
      end else begin
        // Out-of-order digit: drop the partial frame, but a fresh digit 0 restarts it.
        serr_d   = 1'b1;
        shadow_d = '0;
        bad_d    = 1'b0;
        if (de_s2_q == 3'd0) begin
          shadow_d[4*NDIG-1 -: 4] = nib;
          bad_d                   = nib_bad;
          exp_d                   = 3'd1;
        end else begin
          exp_d   = 3'd0;
          state_d = SEQ_HUNT;
        end
      end
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      seg_s1_q <= '0;
      seg_s2_q <= '0;
      de_s1_q  <= '0;
      de_s2_q  <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      state_q  <= SEQ_HUNT;
      exp_q    <= '0;
      shadow_q <= '0;
      bad_q    <= 1'b0;
      time_q   <= '0;
      fv_q     <= 1'b0;
      ferr_q   <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      seg_s1_q <= seg;
      seg_s2_q <= seg_s1_q;
      de_s1_q  <= de;
      de_s2_q  <= de_s1_q;
      prev_q   <= {de_s2_q, seg_s2_q};
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      exp_q    <= exp_d;
      shadow_q <= shadow_d;
      bad_q    <= bad_d;
      time_q   <= time_d;
      fv_q     <= fv_d;
      ferr_q   <= ferr_d;
      serr_q   <= serr_d;
    end
  end

  assign time_bcd    = time_q;
  assign frame_valid = fv_q;
  assign frame_err   = ferr_q;
  assign seq_err     = serr_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;
  localparam int NDIG   = 6;
  localparam int SETTLE = 4;

  logic        mclk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [2:0]  de;
  logic [23:0] time_bcd;
  logic        frame_valid, frame_err, seq_err;

  seg_scan_decoder #(.NDIG(NDIG), .SETTLE(SETTLE)) dut (
    .mclk        (mclk),
    .rst         (rst),
    .seg         (seg),
    .de          (de),
    .time_bcd    (time_bcd),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .seq_err     (seq_err)
  );

  always #5 mclk = ~mclk;

  int checks = 0;
  int errors = 0;

  logic [24:0] act_frames[$];
  logic [24:0] exp_frames[$];
  int          act_seq = 0;
  int          exp_seq = 0;

  // Reference model: digit-level sequencer plus dwell bookkeeping.
  int          m_exp = 0;
  int          m_sh[NDIG];
  bit          m_bad = 0;
  logic [9:0]  last_key;
  bit          last_valid = 0;
  int          last_len = 0;
  bit          last_cap = 0;

  typedef struct {
    logic [23:0] digits;
    logic [23:0] want;
    logic        want_err;
  } vec_t;
  vec_t tbl[5];

  always @(negedge mclk) begin
    if (!rst) begin
      if (frame_valid) act_frames.push_back({frame_err, time_bcd});
      if (seq_err) act_seq++;
    end
  end

  function automatic logic [6:0] pat(int v);
    case (v)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0011111;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void model_capture(int idx, logic [6:0] s);
    int v;
    bit b;
    logic [23:0] t;
    v = 15;
    b = 1;
    t = '0;
    for (int i = 0; i < 10; i++) if (pat(i) == s) begin v = i; b = 0; end
    if (idx == m_exp) begin
      m_sh[idx] = v;
      m_bad = m_bad | b;
      if (idx == NDIG - 1) begin
        for (int i = 0; i < NDIG; i++) t = {t[19:0], 4'(m_sh[i])};
        exp_frames.push_back({m_bad, t});
        m_exp = 0;
        m_bad = 0;
      end else begin
        m_exp++;
      end
    end else if (m_exp != 0) begin
      exp_seq++;
      m_bad = 0;
      for (int i = 0; i < NDIG; i++) m_sh[i] = 0;
      if (idx == 0) begin
        m_sh[0] = v;
        m_bad = b;
        m_exp = 1;
      end else begin
        m_exp = 0;
      end
    end
  endfunction

  function automatic void model_feed(logic [2:0] d, logic [6:0] s, int n);
    if (last_valid && last_key == {d, s}) begin
      last_len += n;
    end else begin
      last_key = {d, s};
      last_len = n;
      last_cap = 0;
      last_valid = 1;
    end
    if (!last_cap && last_len >= SETTLE) begin
      last_cap = 1;
      model_capture(int'(d), s);
    end
  endfunction

  function automatic void model_reset();
    m_exp = 0;
    m_bad = 0;
    last_valid = 0;
  endfunction

  task automatic drive_raw(logic [2:0] d, logic [6:0] s, int n);
    de = d;
    seg = s;
    model_feed(d, s, n);
    repeat (n) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic drive_digit(int d, int v, int n);
    drive_raw(3'(d), pat(v), n);
  endtask

  task automatic drain();
    drive_raw(3'd7, 7'h00, 14);
  endtask

  task automatic drive_scan(logic [23:0] digits, int n);
    for (int d = 0; d < NDIG; d++) drive_digit(d, int'(digits[4*(NDIG-1-d) +: 4]), n);
  endtask

  task automatic check_zero_outputs(string name);
    check({name, " time_bcd"}, 32'(time_bcd), 0);
    check({name, " frame_valid"}, 32'(frame_valid), 0);
    check({name, " frame_err"}, 32'(frame_err), 0);
    check({name, " seq_err"}, 32'(seq_err), 0);
  endtask

  task automatic check_directed(string name, int n_frames, logic [24:0] frame0, int n_seq);
    check({name, " frame count"}, act_frames.size(), n_frames);
    if (n_frames > 0 && act_frames.size() > 0) check({name, " frame"}, act_frames[0], frame0);
    check({name, " seq_err count"}, act_seq, n_seq);
  endtask

  task automatic compare_model(string name);
    check({name, " model frame count"}, act_frames.size(), exp_frames.size());
    for (int i = 0; i < act_frames.size() && i < exp_frames.size(); i++)
      check({name, " model frame"}, act_frames[i], exp_frames[i]);
    check({name, " model seq_err count"}, act_seq, exp_seq);
    act_frames.delete();
    exp_frames.delete();
    act_seq = 0;
    exp_seq = 0;
  endtask

  initial begin
    tbl[0] = '{24'h123456, 24'h123456, 1'b0};
    tbl[1] = '{24'h1234F6, 24'h1234F6, 1'b1};
    tbl[2] = '{24'h000007, 24'h000007, 1'b0};
    tbl[3] = '{24'h235959, 24'h235959, 1'b0};
    tbl[4] = '{24'hF80F19, 24'hF80F19, 1'b1};
    for (int i = 0; i < NDIG; i++) m_sh[i] = 0;

    rst = 1'b1;
    de = 3'd7;
    seg = 7'h00;
    repeat (3) @(posedge mclk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;
    drain();

    for (int i = 0; i < 5; i++) begin
      drive_scan(tbl[i].digits, 10);
      drain();
      check_directed($sformatf("table%0d", i), 1, {tbl[i].want_err, tbl[i].want}, 0);
      compare_model($sformatf("table%0d", i));
    end

    drive_digit(0, 1, 10);
    drive_digit(1, 2, 10);
    drive_digit(2, 8, 1);
    drive_digit(2, 3, 1);
    drive_digit(2, 8, 1);
    drive_digit(2, 3, 10);
    drive_digit(3, 4, 10);
    drive_digit(4, 5, 10);
    drive_digit(5, 6, 10);
    drain();
    check_directed("glitch", 1, {1'b0, 24'h123456}, 0);
    compare_model("glitch");

    drive_digit(0, 1, 10);
    drive_digit(1, 2, 10);
    drive_digit(3, 4, 10);
    drain();
    check_directed("order", 0, '0, 1);
    compare_model("order");
    drive_scan(24'h000007, 10);
    drain();
    check_directed("after order", 1, {1'b0, 24'h000007}, 0);
    compare_model("after order");

    for (int d = 0; d < 4; d++) drive_digit(d, d + 1, 10);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge mclk);
    #1;
    check_zero_outputs("mid reset");
    rst = 1'b0;
    drive_digit(3, 4, 8);
    drive_digit(4, 5, 10);
    drive_digit(5, 6, 10);
    drive_raw(3'd6, pat(0), 10);
    drain();
    check_directed("post reset tail", 0, '0, 0);
    compare_model("post reset tail");
    drive_scan(24'h123456, 10);
    drain();
    check_directed("post reset scan", 1, {1'b0, 24'h123456}, 0);
    compare_model("post reset scan");

    drive_digit(0, 1, 10);
    drive_digit(1, 2, 3);
    drive_digit(2, 3, 10);
    drive_digit(3, 4, 10);
    drive_digit(4, 5, 10);
    drive_digit(5, 6, 10);
    drain();
    check_directed("short dwell", 0, '0, 1);
    compare_model("short dwell");

    for (int sc = 0; sc < 40; sc++) begin
      for (int d = 0; d < NDIG; d++) begin
        int v;
        int n;
        if ($urandom_range(0, 19) == 0) continue;
        v = ($urandom_range(0, 11) == 0) ? 15 : int'($urandom_range(0, 9));
        n = int'($urandom_range(2, 12));
        drive_digit(d, v, n);
        if ($urandom_range(0, 24) == 0) drive_raw(3'($urandom_range(6, 7)), pat(int'($urandom_range(0, 9))), 6);
      end
    end
    drain();
    compare_model("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
